// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared FSM encoding and vector-memory field selects for the AES vector sequencer
package aes_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  localparam logic [1:0] SEL_KEY = 2'd0;
  localparam logic [1:0] SEL_PT  = 2'd1;
  localparam logic [1:0] SEL_EXP = 2'd2;
endpackage

// File: rtl/aes_vec_mem.sv
// aes_vec_mem: key/plaintext/expected register arrays with one decoded write port and combinational reads
module aes_vec_mem
  import aes_seq_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int DATA_W  = 128,
  parameter int IW      = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [1:0]        sel_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IW-1:0]     rd_idx_i,
  input  logic [IW-1:0]     exp_idx_i,
  output logic [DATA_W-1:0] key_o,
  output logic [DATA_W-1:0] pt_o,
  output logic [DATA_W-1:0] exp_o
);
  logic [DATA_W-1:0] key_q [NUM_VEC];
  logic [DATA_W-1:0] pt_q  [NUM_VEC];
  logic [DATA_W-1:0] exp_q [NUM_VEC];
  always_ff @(posedge clk) begin
    if (we_i && sel_i == SEL_KEY) key_q[wr_idx_i] <= wr_data_i;
    if (we_i && sel_i == SEL_PT)  pt_q[wr_idx_i]  <= wr_data_i;
    if (we_i && sel_i == SEL_EXP) exp_q[wr_idx_i] <= wr_data_i;
  end
  assign key_o = key_q[rd_idx_i];
  assign pt_o  = pt_q[rd_idx_i];
  assign exp_o = exp_q[exp_idx_i];
endmodule

// File: rtl/aes_vector_sequencer.sv
// aes_vector_sequencer: drives the AES core from stored vectors and scores pass/fail/timeout.
// Define AES_SEQ_MISMATCH_LOG_EN to add first-mismatch capture outputs (mm_valid, mm_idx, mm_data).
module aes_vector_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NUM_VEC  = 4,
  parameter int DATA_W   = 128,
  parameter int EN_HOLD  = 1,
  parameter int TIMEOUT  = 64,
  localparam int IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int CW = $clog2(NUM_VEC + 1)
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              vec_wr_en,
  input  logic [IW-1:0]     vec_wr_idx,
  input  logic [1:0]        vec_wr_sel,
  input  logic [DATA_W-1:0] vec_wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic [CW-1:0]     tmo_cnt,
`ifdef AES_SEQ_MISMATCH_LOG_EN
  output logic              mm_valid,
  output logic [IW-1:0]     mm_idx,
  output logic [DATA_W-1:0] mm_data,
`endif
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [DATA_W-1:0] AES_key_in,
  input  logic [DATA_W-1:0] AES_data_out,
  input  logic              AES_data_out_valid
);
  localparam int TW = $clog2(((EN_HOLD > TIMEOUT) ? EN_HOLD : TIMEOUT) + 1);
  state_e            st_q;
  logic              start_q, busy_q, done_q, en_q;
  logic [DATA_W-1:0] pt_q, key_q;
  logic [IW-1:0]     idx_q, rd_idx;
  logic [TW-1:0]     cnt_q;
  logic [CW-1:0]     pass_q, fail_q, tmo_q;
  logic [DATA_W-1:0] mem_key, mem_pt, mem_exp;
  logic              last, tmo_hit, res, match, ok;
  assign last    = idx_q == IW'(NUM_VEC - 1);
  assign tmo_hit = st_q == WAIT && cnt_q == TW'(TIMEOUT - 1);
  assign res     = (st_q == ISSUE || st_q == WAIT) && (AES_data_out_valid || tmo_hit);
  assign match   = AES_data_out == mem_exp;
  assign ok      = AES_data_out_valid && match;
  // read port looks ahead so the next vector loads on the same edge that scores the current one
  assign rd_idx  = (st_q == IDLE || last) ? '0 : idx_q + 1'b1;
  aes_vec_mem #(.NUM_VEC(NUM_VEC), .DATA_W(DATA_W), .IW(IW)) u_mem (
    .clk(AES_clk), .we_i(vec_wr_en && st_q == IDLE), .sel_i(vec_wr_sel),
    .wr_idx_i(vec_wr_idx), .wr_data_i(vec_wr_data), .rd_idx_i(rd_idx),
    .exp_idx_i(idx_q), .key_o(mem_key), .pt_o(mem_pt), .exp_o(mem_exp)
  );
  always_ff @(posedge AES_clk) begin
    start_q <= start & ~AES_rst;
    done_q  <= 1'b0;
    if (AES_rst) begin
      st_q   <= IDLE;
      busy_q <= 1'b0;
      en_q   <= 1'b0;
      pt_q   <= '0;
      key_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      tmo_q  <= '0;
    end else begin
      case (st_q)
        IDLE: if (start_q) begin
          st_q   <= ISSUE;
          busy_q <= 1'b1;
          en_q   <= 1'b1;
          pt_q   <= mem_pt;
          key_q  <= mem_key;
          idx_q  <= '0;
          cnt_q  <= '0;
          pass_q <= '0;
          fail_q <= '0;
          tmo_q  <= '0;
        end
        ISSUE, WAIT: if (res) begin
          pass_q <= pass_q + CW'(ok);
          fail_q <= fail_q + CW'(!ok);
          tmo_q  <= tmo_q + CW'(!AES_data_out_valid);
          if (last) begin
            st_q   <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            en_q   <= 1'b0;
          end else begin
            st_q  <= ISSUE;
            idx_q <= idx_q + 1'b1;
            en_q  <= 1'b1;
            pt_q  <= mem_pt;
            key_q <= mem_key;
            cnt_q <= '0;
          end
        end else if (st_q == ISSUE && cnt_q == TW'(EN_HOLD - 1)) begin
          st_q  <= WAIT;
          en_q  <= 1'b0;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        default: st_q <= IDLE;
      endcase
    end
  end
`ifdef AES_SEQ_MISMATCH_LOG_EN
  logic              mm_valid_q;
  logic [IW-1:0]     mm_idx_q;
  logic [DATA_W-1:0] mm_data_q;
  always_ff @(posedge AES_clk) begin
    if (AES_rst || (st_q == IDLE && start_q)) begin
      mm_valid_q <= 1'b0;
      mm_idx_q   <= '0;
      mm_data_q  <= '0;
    end else if (res && AES_data_out_valid && !match && !mm_valid_q) begin
      mm_valid_q <= 1'b1;
      mm_idx_q   <= idx_q;
      mm_data_q  <= AES_data_out;
    end
  end
  assign mm_valid = mm_valid_q;
  assign mm_idx   = mm_idx_q;
  assign mm_data  = mm_data_q;
`endif
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign tmo_cnt     = tmo_q;
  assign AES_en      = en_q;
  assign AES_data_in = pt_q;
  assign AES_key_in  = key_q;
endmodule

// File: tb/tb_aes_vector_sequencer.sv
// tb_aes_vector_sequencer: directed and randomized runs against a mock AES core whose
// per-vector answer delay and corruption are planned up front; expectations come from that plan
module tb_aes_vector_sequencer;
  import aes_seq_pkg::*;
  localparam int NV = 4, DW = 128, EH = 2, TMO = 16;
  logic          AES_clk = 1'b0, AES_rst = 1'b1;
  logic          vec_wr_en = 1'b0, start = 1'b0;
  logic [1:0]    vec_wr_idx = '0, vec_wr_sel = '0;
  logic [DW-1:0] vec_wr_data = '0;
  logic          busy, done, AES_en;
  logic [2:0]    pass_cnt, fail_cnt, tmo_cnt;
  logic [DW-1:0] AES_data_in, AES_key_in;
  logic [DW-1:0] AES_data_out = '0;
  logic          AES_data_out_valid = 1'b0;
`ifdef AES_SEQ_MISMATCH_LOG_EN
  logic          mm_valid;
  logic [1:0]    mm_idx;
  logic [DW-1:0] mm_data;
`endif
  logic [DW-1:0] key_v [NV], pt_v [NV], ex [NV], cor [NV];
  int            w [NV];
  int            vi = 0, checks = 0, errors = 0;
  bit            stray = 1'b0;
  int            due_q [$], k_q [$];

  aes_vector_sequencer #(.NUM_VEC(NV), .DATA_W(DW), .EN_HOLD(EH), .TIMEOUT(TMO)) dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst), .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx),
    .vec_wr_sel(vec_wr_sel), .vec_wr_data(vec_wr_data), .start(start), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt),
`ifdef AES_SEQ_MISMATCH_LOG_EN
    .mm_valid(mm_valid), .mm_idx(mm_idx), .mm_data(mm_data),
`endif
    .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
    .AES_data_out(AES_data_out), .AES_data_out_valid(AES_data_out_valid)
  );

  initial forever #5 AES_clk = ~AES_clk;
  initial begin
    #2000000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

  // mock core: answers vector k on its w[k]-th WAIT cycle, never if w[k] > TMO
  initial begin
    int cyc;
    bit pe;
    cyc = 0;
    pe  = 1'b0;
    forever begin
      @(posedge AES_clk);
      #2;
      cyc++;
      if (AES_rst) begin
        due_q.delete();
        k_q.delete();
      end else if (pe && !AES_en) begin
        if (vi < NV && w[vi] <= TMO) begin
          due_q.push_back(cyc + w[vi] - 1);
          k_q.push_back(vi);
        end
        vi++;
      end
      pe = AES_en;
      AES_data_out_valid = stray;
      AES_data_out = stray ? ex[0] : '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        AES_data_out_valid = 1'b1;
        AES_data_out = ex[k_q[0]] ^ cor[k_q[0]];
        void'(due_q.pop_front());
        void'(k_q.pop_front());
      end
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [1:0] sel, input logic [DW-1:0] d);
    vec_wr_en = 1'b1;
    vec_wr_idx = 2'(idx);
    vec_wr_sel = sel;
    vec_wr_data = d;
    tick();
    vec_wr_en = 1'b0;
  endtask

  task automatic load();
    for (int k = 0; k < NV; k++) begin
      wr(k, SEL_KEY, key_v[k]);
      wr(k, SEL_PT, pt_v[k]);
      wr(k, SEL_EXP, ex[k]);
    end
  endtask

  task automatic plan(input int ww);
    for (int k = 0; k < NV; k++) begin
      w[k] = ww;
      cor[k] = '0;
    end
  endtask

  function automatic int gap(input int k);
    return (w[k] <= TMO) ? w[k] : TMO;
  endfunction

  task automatic kick(input bit hold);
    vi = 0;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  task automatic watch(input bit mid_wr);
    int k, hi, lo;
    bit pe;
    k = 0; hi = 0; lo = 0; pe = 1'b0;
    check("t0_busy", DW'(busy), DW'(0));
    check("t0_en", DW'(AES_en), DW'(0));
    check("t0_done", DW'(done), DW'(0));
    for (int t = 1; t < 1000; t++) begin
      tick();
      if (done) begin
        check("done_busy", DW'(busy), DW'(0));
        check("done_nvec", DW'(k), DW'(NV));
        check("last_gap", DW'(lo), DW'(gap(NV - 1)));
        return;
      end
      check("busy", DW'(busy), DW'(1));
      if (AES_en) begin
        if (!pe) begin
          if (k > 0) check("gap", DW'(lo), DW'(gap(k - 1)));
          k++;
          hi = 0;
        end
        hi++;
        check("pt", AES_data_in, pt_v[k - 1]);
        check("key", AES_key_in, key_v[k - 1]);
      end else begin
        if (pe) begin
          check("en_hold", DW'(hi), DW'(EH));
          lo = 0;
        end
        lo++;
      end
      pe = AES_en;
      vec_wr_en = mid_wr && t == 3;
      vec_wr_sel = SEL_EXP;
      vec_wr_idx = 2'd3;
      vec_wr_data = ~ex[3];
    end
    vec_wr_en = 1'b0;
    check("run_bound", DW'(0), DW'(1));
  endtask

  task automatic counts();
    int p, t;
`ifdef AES_SEQ_MISMATCH_LOG_EN
    int mk;
    mk = -1;
    for (int k = 0; k < NV; k++) if (mk < 0 && w[k] <= TMO && cor[k] != '0) mk = k;
    check("mm_valid", DW'(mm_valid), DW'(mk >= 0));
    if (mk >= 0) begin
      check("mm_idx", DW'(mm_idx), DW'(mk));
      check("mm_data", mm_data, ex[mk] ^ cor[mk]);
    end
`endif
    p = 0; t = 0;
    for (int k = 0; k < NV; k++) begin
      if (w[k] > TMO) t++;
      else if (cor[k] == '0) p++;
    end
    check("pass_cnt", DW'(pass_cnt), DW'(p));
    check("fail_cnt", DW'(fail_cnt), DW'(NV - p));
    check("tmo_cnt", DW'(tmo_cnt), DW'(t));
  endtask

  task automatic zeros(input string tag);
    check({tag, "_busy"}, DW'(busy), DW'(0));
    check({tag, "_done"}, DW'(done), DW'(0));
    check({tag, "_en"}, DW'(AES_en), DW'(0));
    check({tag, "_data"}, AES_data_in, '0);
    check({tag, "_key"}, AES_key_in, '0);
    check({tag, "_cnts"}, DW'({pass_cnt, fail_cnt, tmo_cnt}), DW'(0));
`ifdef AES_SEQ_MISMATCH_LOG_EN
    check({tag, "_mm"}, DW'(mm_valid), DW'(0));
`endif
  endtask

  task automatic run();
    kick(1'b0);
    watch(1'b0);
    counts();
  endtask

  initial begin
    plan(10);
    repeat (3) tick();
    zeros("reset");
    AES_rst = 1'b0;
    for (int k = 0; k < NV; k++) begin
      key_v[k] = 128'h000102030405060708090a0b0c0d0e0f;
      pt_v[k]  = 128'h00112233445566778899aabbccddeeff ^ DW'(k);
      ex[k]    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    end
    load();
    plan(10);
    run();
    plan(10);
    cor[2] = DW'(1);
    run();
    plan(10);
    w[1] = TMO + 1;
    run();
    plan(10);
    w[0] = TMO;
    w[3] = TMO;
    run();
    plan(10);
    kick(1'b0);
    for (int i = 0; i < 200 && !(AES_en && AES_data_in == pt_v[2]); i++) tick();
    check("rst_reach", DW'(AES_en && AES_data_in == pt_v[2]), DW'(1));
    AES_rst = 1'b1;
    tick();
    zeros("midrst");
    tick();
    AES_rst = 1'b0;
    tick();
    run();
    plan(10);
    kick(1'b1);
    watch(1'b1);
    counts();
    vi = 0;
    tick();
    start = 1'b0;
    watch(1'b0);
    counts();
    repeat (2) tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) tick();
    counts();
    check("idle_busy", DW'(busy), DW'(0));
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NV; k++) begin
        pt_v[k] = {$urandom, $urandom, $urandom, $urandom};
        ex[k]   = {$urandom, $urandom, $urandom, $urandom};
        w[k]    = $urandom_range(1, TMO + 1);
        cor[k]  = ($urandom_range(0, 2) == 0) ? (DW'(1) << $urandom_range(0, DW - 1)) : '0;
      end
      load();
      run();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_vector_sequencer.md
# aes_vector_sequencer

Synthesizable, self-checking stimulus engine for the AES core. It drives the core's `AES_en`, `AES_data_in` and `AES_key_in` inputs from an internal vector memory of NUM_VEC {key, plaintext, expected ciphertext} triples. It waits on `AES_data_out_valid`, compares `AES_data_out` against the expected value, and keeps pass, fail and timeout counters. It sits beside `AES_top` in on-chip test builds and is the parametrised successor of the single-vector directed stimulus flow.

## Interface
Parameters:
- NUM_VEC, 4: number of stored vectors (≥1).
- DATA_W, 128: block and key width.
- EN_HOLD, 1: cycles `AES_en` is held high per vector (≥1).
- TIMEOUT, 64: cycles to wait for valid after `AES_en` drops before declaring a timeout (≥1).

Ports (clock and reset first). **One clock; reset is synchronous and active-high.**
- AES_clk  in  1  sole clock.
- AES_rst  in  1  synchronous active-high reset.
- vec_wr_en  in  1  vector-memory write strobe.
- vec_wr_idx  in  $clog2(NUM_VEC)  vector index.
- vec_wr_sel  in  2  field select: 0 = key, 1 = plaintext, 2 = expected, 3 = ignored.
- vec_wr_data  in  DATA_W  write data.
- start  in  1  run request, level-sampled.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt, fail_cnt, tmo_cnt  out  $clog2(NUM_VEC+1)  result counters.
- AES_en  out  1  core enable.
- AES_data_in  out  DATA_W  plaintext to core.
- AES_key_in  out  DATA_W  key to core.
- AES_data_out  in  DATA_W  core result.
- AES_data_out_valid  in  1  core result strobe.

## Operation
- FSM states and transitions:
  - IDLE: `start`=1 → ISSUE; the vector index and all counters are cleared.
  - ISSUE: `AES_en`=1 and `AES_data_in`/`AES_key_in` = vec[idx] for EN_HOLD cycles, then → WAIT.
  - WAIT: `AES_en`=0 and the timeout counter runs.
  - DONE: one cycle, `done`=1, then → IDLE.
- Valid is sampled in both ISSUE and WAIT.
- On a sampled valid:
  - `AES_data_out` == expected[idx] → pass_cnt+1, otherwise fail_cnt+1.
  - Then: idx == NUM_VEC−1 → DONE, else idx+1 → ISSUE.
- Timeout: the WAIT counter reaches TIMEOUT with no valid → fail_cnt+1 and tmo_cnt+1, then advance as for a valid.
- Valid in the same cycle the timeout expires: valid wins, no timeout is counted.
- A valid seen in IDLE or DONE is ignored.
- `start` while busy is ignored.
- Vector-memory writes are accepted only in IDLE and ignored otherwise.
- Reset effects:
  - Reset mid-run aborts immediately: FSM → IDLE and all outputs return to reset values.
  - The vector memory has no reset and its contents survive.
- Counters hold their values after DONE until the next start.
- Comparison is a full DATA_W equality with no masking.
- Counters never wrap, because pass + fail ≤ NUM_VEC.

## Timing
- Reset values:
  - `AES_en`, `busy`, `done` = 0.
  - `AES_data_in`, `AES_key_in` = 0.
  - All counters = 0.
- All outputs are registered.
- Start latency: `start` sampled at edge N → `busy`, `AES_en` and the vector-0 data are valid after edge N+1.
- `AES_en` stays high through edge N+EN_HOLD+1, then drops.
- `AES_data_in` and `AES_key_in` hold their vector value until the next ISSUE.
- Valid sampled at edge M:
  - Counters update after edge M.
  - The next vector's `AES_en` rises after edge M, so back-to-back issue has zero idle cycles.
- After the final valid at edge M, `done`=1 and `busy`=0 follow edge M for one cycle.
- Timeout fires on the TIMEOUT-th WAIT cycle without a valid.

## Configuration
- `AES_SEQ_MISMATCH_LOG_EN` defined:
  - Adds outputs `mm_valid` (1), `mm_idx` ($clog2(NUM_VEC)) and `mm_data` (DATA_W).
  - They capture the index and observed `AES_data_out` of the first mismatch of a run.
  - Timeouts are not captured.
  - These outputs clear on start and on reset.
- Undefined: these ports and registers are absent; everything else is identical.

## Structure
- Shared package `aes_seq_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT, DONE).
  - Field-select constants SEL_KEY, SEL_PT, SEL_EXP.
- Sub-module `aes_vec_mem`:
  - Three DATA_W × NUM_VEC register arrays.
  - Write port decoded by vec_wr_sel.
  - Combinational read by idx.
- The top level holds the FSM, the hold/timeout counter and the result counters.

## Test plan
All scenarios use a bench core model that returns the expected value 10 cycles after `AES_en` falls, unless noted. The four vectors use key 000102…0f, plaintext 00112233…eeff and expected 69c4e0d86a7b0430d8cdb78070b4c55a, with the plaintext varied per vector.
1. All vectors match → pass=4, fail=0, tmo=0; exactly one `done` pulse; `busy` high from start+1 until done.
2. Model corrupts bit 0 of vector 2 → pass=3, fail=1; with the macro defined, mm_idx=2 and mm_data equals the corrupted value.
3. Model never answers vector 1, with TIMEOUT=16 → fail=1, tmo=1, pass=3; vector 2's `AES_en` rises 16 WAIT cycles after vector 1's `AES_en` fell.
4. Valid arrives exactly on the TIMEOUT-th WAIT cycle → counted as a pass; tmo=0.
5. `AES_rst` pulsed during vector 2 of a run, then restarted:
   - During the pulse: outputs return to zero.
   - After the rerun: pass=4, showing the vectors were retained.
6. `start` held high and a vector write issued mid-run → no restart, write ignored; after DONE with `start` still high, a new run begins the next cycle.
